bist_response_analyzer: RTL and testbench

Response side of the on-chip logic BIST: sequences scan_en for the scan-chain CUT and compacts the seven SO_chain outputs into a 7-bit MISR. It uses the same x^7 + x^6 + 1 feedback as the TPG/compactor LFSRs. At the end of the run it compares the signature with a golden value and reports pass/fail. It sits beside the TPG muxes and is driven by the test controller.

---
 rtl/bist_response_analyzer.sv | 142 ++++++++++++++
 tb/tb_bist_response_analyzer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// Logic-BIST response side: sequences scan_en, compacts seven scan-out chains into a
// 7-bit MISR (x^7 + x^6 + 1) and reports pass/fail. Optional macro: BIST_XMASK_EN.
module bist_response_analyzer #(
  parameter int CHAIN_LEN    = 8,
  parameter int NUM_PATTERNS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] so_chain,
  input  logic [6:0] golden_sig,
`ifdef BIST_XMASK_EN
  input  logic [6:0] x_mask,
`endif
  output logic       scan_en,
  output logic       bist_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] signature,
  output logic [2:0] dbg_state
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_MAX    = PW'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE; busy is
  // the acknowledgement, done/pass are a level result that stays valid until the next start.
  state_t        r_state, w_state_next;
  logic [SW-1:0] r_shift_cnt, w_shift_cnt_next;
  logic [PW-1:0] r_pat_cnt, w_pat_cnt_next;
  logic [6:0]    r_misr, w_misr_next, w_misr_comp, w_d;
  logic          r_pass, w_pass_next;
  logic          r_scan_en, r_busy, r_done;

`ifdef BIST_XMASK_EN
  assign w_d = so_chain & ~x_mask;
`else
  assign w_d = so_chain;
`endif

  assign w_misr_comp[0]   = r_misr[6] ^ w_d[0];
  assign w_misr_comp[5:1] = r_misr[4:0] ^ w_d[5:1];
  assign w_misr_comp[6]   = r_misr[5] ^ r_misr[6] ^ w_d[6];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_misr      <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift_cnt <= w_shift_cnt_next;
      r_pat_cnt   <= w_pat_cnt_next;
      r_misr      <= w_misr_next;
      r_pass      <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shift_cnt_next = r_shift_cnt;
    w_pat_cnt_next   = r_pat_cnt;
    w_misr_next      = r_misr;
    w_pass_next      = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next     = S_LOAD;
          w_shift_cnt_next = '0;
          w_pat_cnt_next   = '0;
          w_misr_next      = '0;
          w_pass_next      = 1'b0;
        end
      end
      S_LOAD: begin
        // Chains hold reset garbage here, so nothing is compacted.
        if (r_shift_cnt == SHIFT_LAST) begin
          w_shift_cnt_next = '0;
          w_state_next     = S_CAPTURE;
        end else begin
          w_shift_cnt_next = r_shift_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_pat_cnt_next = r_pat_cnt + 1'b1;
        w_state_next   = S_SHIFT;
      end
      S_SHIFT: begin
        w_misr_next = w_misr_comp;
        if (r_shift_cnt == SHIFT_LAST) begin
          w_shift_cnt_next = '0;
          if (r_pat_cnt < PAT_MAX) begin
            w_state_next = S_CAPTURE;
          end else begin
            // Compare the final signature as it is written, so pass rises with done.
            w_state_next = S_DONE;
            w_pass_next  = (w_misr_comp == golden_sig);
          end
        end else begin
          w_shift_cnt_next = r_shift_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_scan_en <= (w_state_next == S_LOAD) || (w_state_next == S_SHIFT);
      r_busy    <= (w_state_next == S_LOAD) || (w_state_next == S_CAPTURE) ||
                   (w_state_next == S_SHIFT);
      r_done    <= (w_state_next == S_DONE);
    end
  end

  assign scan_en   = r_scan_en;
  assign bist_en   = r_busy;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboarded bench for bist_response_analyzer: random runs against a schedule-level
// MISR model; a negedge monitor checks every busy cycle and each completed run.
module tb_bist_response_analyzer;

  localparam int CL      = 4;
  localparam int NP      = 2;
  localparam int RUN_LEN = CL + NP * (CL + 1);

  logic       clk = 1'b0;
  logic       reset, start;
  logic [6:0] so_chain, golden_sig, x_mask;
  logic       scan_en, bist_en, busy, done, pass;
  logic [6:0] signature;
  logic [2:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];  // {pass, signature} per completed run

  bist_response_analyzer #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .so_chain  (so_chain),
    .golden_sig(golden_sig),
`ifdef BIST_XMASK_EN
    .x_mask    (x_mask),
`endif
    .scan_en   (scan_en),
    .bist_en   (bist_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // MISR as a rotate-left with an extra tap from bit 6 into bit 6.
  function automatic logic [6:0] misr_step(input logic [6:0] q, input logic [6:0] d);
    logic [6:0] rot;
    rot = {q[5:0], q[6]};
    return rot ^ {q[6], 6'b0} ^ d;
  endfunction

  // Busy cycle p is a compacting shift unless it is in the preload or a capture slot.
  function automatic bit is_shift(input int p);
    return (p >= CL) && (((p - CL) % (CL + 1)) != 0);
  endfunction

  // mode: 0 random, 1 all-zero response, 2 single bit good golden, 3 single bit bad golden
  task automatic run(input int mode, input bit inject_start);
    logic [6:0] stream[RUN_LEN];
    logic [6:0] mask;
    logic [6:0] sig;
    logic [6:0] gold;
    sig  = 7'h00;
    mask = 7'h00;
    for (int p = 0; p < RUN_LEN; p++)
      stream[p] = (mode == 0) ? 7'($urandom) : 7'h00;
    if (mode >= 2) stream[CL + 1] = 7'h01;
`ifdef BIST_XMASK_EN
    if (mode == 0) mask = ($urandom_range(0, 2) == 0) ? 7'h7F : 7'($urandom);
`endif
    for (int p = 0; p < RUN_LEN; p++)
      if (is_shift(p)) sig = misr_step(sig, stream[p] & ~mask);
    case (mode)
      0:       gold = ($urandom_range(0, 1) == 0) ? sig : 7'($urandom);
      3:       gold = sig ^ 7'h01;
      default: gold = sig;
    endcase
    @(posedge clk); #1;
    start      = 1'b1;
    golden_sig = gold;
    x_mask     = mask;
    for (int p = 0; p < RUN_LEN; p++) begin
      @(posedge clk); #1;
      start    = inject_start && ($urandom_range(0, 3) == 0);
      so_chain = stream[p];
    end
    exp_q.push_back({(gold == sig), sig});
    @(posedge clk); #1;
    start    = 1'b0;
    so_chain = 7'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  // Monitor: per-cycle shape of the busy window and the result at each done rise.
  int busy_cnt   = 0;
  bit prev_busy  = 1'b0;
  bit prev_done  = 1'b0;
  logic [7:0] exp_res;
  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) busy_cnt = 0;
      check("busy_cycle_outputs", {29'd0, bist_en, scan_en, done},
            {29'd0, 1'b1, is_shift(busy_cnt) || (busy_cnt < CL), 1'b0});
      busy_cnt++;
    end
    if (done && !prev_done) begin
      check("busy_length", busy_cnt, RUN_LEN);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
      end else begin
        exp_res = exp_q.pop_front();
        check("signature", {25'd0, signature}, {25'd0, exp_res[6:0]});
        check("pass", {31'd0, pass}, {31'd0, exp_res[7]});
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    so_chain   = 7'h00;
    golden_sig = 7'h00;
    x_mask     = 7'h00;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_outputs", {25'd0, scan_en, bist_en, busy, done, pass, 2'b0}, 32'd0);
    check("reset_signature", {25'd0, signature}, 32'd0);
    @(negedge clk);
    check("start_with_reset_ignored", {31'd0, busy}, 32'd0);

    run(1, 1'b0);
    run(2, 1'b1);
    run(3, 1'b0);

    // Abort mid-SHIFT after some response has been compacted.
    @(posedge clk); #1;
    start = 1'b1;
    for (int p = 0; p < CL + 3; p++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      so_chain = 7'($urandom) | 7'h01;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", {25'd0, scan_en, bist_en, busy, done, pass, 2'b0}, 32'd0);
    check("abort_signature", {25'd0, signature}, 32'd0);

    for (int r = 0; r < 24; r++) run(0, r[0]);
    run(2, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
